// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm
// Multi-cycle MIPS-style control unit. Sequences FETCH / DECODE / EXEC / MEM /
// WB / BRANCH / JUMP and falls into an absorbing TRAP on an illegal opcode or
// a memory wait timeout.
//
// Parameters
//   MEM_HS    : 1 = memory phases wait for mem_ready, 0 = single-cycle memory
//   WAIT_MAX  : max wait cycles per memory phase, 0 disables the timeout
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   Instruction     : memory read data, latched into IR when a fetch completes
//   mem_ready       : memory access completes this cycle (FETCH/MEM only)
//   PCWrite .. BNE  : 1-bit datapath controls
//   ALUSrcB, PCSrc, SigSize (2b), ALUOp (3b) : datapath selects
//   State (3b)      : current state encoding
//   Illegal, Timeout: sticky status flags, cleared only by reset
// ---------------------------------------------------------------------------
module mc_ctrl_fsm #(
  parameter int MEM_HS   = 1,
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instruction,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        RegDst,
  output logic        RetAdd,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic        ExtType,
  output logic        BEQ,
  output logic        BNE,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSrc,
  output logic [1:0]  SigSize,
  output logic [2:0]  ALUOp,
  output logic [2:0]  State,
  output logic        Illegal,
  output logic        Timeout
);

  // A zero-width counter is not legal, so WAIT_MAX=0 still gets one bit.
  localparam int CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_JUMP   = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  state_t        r_state, w_state_next;
  logic [31:0]   r_ir;
  logic [CW-1:0] r_wait_cnt, w_wait_cnt_next;
  logic          r_illegal, r_timeout;
  logic          w_illegal_set, w_timeout_set, w_ir_load;

  // Raw enables; the ones that can corrupt architectural state are masked by rst.
  logic w_pc_write, w_ir_write, w_mem_read, w_mem_write, w_reg_write;

  // Instruction fields and class decode from the held IR.
  logic [5:0] w_op, w_funct;
  logic       w_is_r, w_is_jr, w_is_jal, w_is_j, w_is_beq, w_is_bne;
  logic       w_is_load, w_is_store, w_is_imm_alu;

  assign w_op         = r_ir[31:26];
  assign w_funct      = r_ir[5:0];
  assign w_is_r       = (w_op == 6'h00);
  assign w_is_jr      = w_is_r && (w_funct == 6'b001000);
  assign w_is_j       = (w_op == 6'h02);
  assign w_is_jal     = (w_op == 6'h03);
  assign w_is_beq     = (w_op == 6'h04);
  assign w_is_bne     = (w_op == 6'h05);
  assign w_is_load    = (w_op inside {6'h20, 6'h21, 6'h23});
  assign w_is_store   = (w_op inside {6'h28, 6'h29, 6'h2B});
  assign w_is_imm_alu = (w_op inside {6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F});

  // Completion of a memory phase; without handshake every access is one cycle.
  logic w_done;
  assign w_done = (MEM_HS == 0) ? 1'b1 : mem_ready;

  // Timeout fires only when the counter has reached the limit and the access
  // is still outstanding; a completion in that cycle wins.
  logic w_at_limit;
  assign w_at_limit = (WAIT_MAX > 0) && (r_wait_cnt == CW'(WAIT_MAX));

  // Saturating increment used while a memory phase is stalled.
  logic [CW-1:0] w_wait_inc;
  assign w_wait_inc = (r_wait_cnt == {CW{1'b1}}) ? r_wait_cnt : r_wait_cnt + 1'b1;

  // State register, IR and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_ir       <= 32'd0;
      r_wait_cnt <= '0;
      r_illegal  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      if (w_ir_load)     r_ir      <= Instruction;
      if (w_illegal_set) r_illegal <= 1'b1;
      if (w_timeout_set) r_timeout <= 1'b1;
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = '0;
    w_illegal_set   = 1'b0;
    w_timeout_set   = 1'b0;
    w_ir_load       = 1'b0;
    w_pc_write      = 1'b0;
    w_ir_write      = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_reg_write     = 1'b0;
    IorD            = 1'b0;
    MemtoReg        = 1'b0;
    RegDst          = 1'b0;
    RetAdd          = 1'b0;
    ALUSrcA         = 1'b0;
    ExtType         = 1'b0;
    BEQ             = 1'b0;
    BNE             = 1'b0;
    ALUSrcB         = 2'b00;
    PCSrc           = 2'b00;
    SigSize         = 2'b11;
    ALUOp           = 3'b000;

    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        SigSize    = 2'b10;
        ALUSrcB    = 2'b01;
        if (w_done) begin
          w_ir_write   = 1'b1;
          w_pc_write   = 1'b1;
          w_ir_load    = 1'b1;
          w_state_next = S_DECODE;
        end else if (w_at_limit) begin
          w_timeout_set = 1'b1;
          w_state_next  = S_TRAP;
        end else begin
          w_wait_cnt_next = w_wait_inc;
        end
      end

      S_DECODE: begin
        ALUSrcB = 2'b11;
        if (w_is_jr || w_is_j || w_is_jal) begin
          w_state_next = S_JUMP;
        end else if (w_is_r || w_is_imm_alu || w_is_load || w_is_store) begin
          w_state_next = S_EXEC;
        end else if (w_is_beq || w_is_bne) begin
          w_state_next = S_BRANCH;
        end else begin
          w_illegal_set = 1'b1;
          w_state_next  = S_TRAP;
        end
      end

      S_EXEC: begin
        ALUSrcA = 1'b1;
        if (w_is_r) begin
          ALUSrcB = 2'b00;
          ALUOp   = 3'b010;
        end else begin
          ALUSrcB = 2'b10;
          case (w_op)
            6'h0A:   ALUOp = 3'b111;
            6'h0C:   ALUOp = 3'b011;
            6'h0D:   ALUOp = 3'b100;
            6'h0E:   ALUOp = 3'b101;
            6'h0F:   ALUOp = 3'b110;
            default: ALUOp = 3'b000;
          endcase
        end
        // Logical immediates are zero-extended, everything else sign-extended.
        ExtType      = (w_op inside {6'h0C, 6'h0D, 6'h0E});
        w_state_next = (w_is_load || w_is_store) ? S_MEM : S_WB;
      end

      S_MEM: begin
        IorD        = 1'b1;
        // Low two opcode bits distinguish byte / half / word for both loads and stores.
        case (w_op[1:0])
          2'b00:   SigSize = 2'b00;
          2'b01:   SigSize = 2'b01;
          default: SigSize = 2'b10;
        endcase
        w_mem_read  = w_is_load;
        w_mem_write = w_is_store;
        if (w_done) begin
          w_state_next = w_is_load ? S_WB : S_FETCH;
        end else if (w_at_limit) begin
          w_timeout_set = 1'b1;
          w_state_next  = S_TRAP;
        end else begin
          w_wait_cnt_next = w_wait_inc;
        end
      end

      S_WB: begin
        w_reg_write  = 1'b1;
        RegDst       = w_is_r;
        MemtoReg     = w_is_load;
        w_state_next = S_FETCH;
      end

      S_BRANCH: begin
        ALUSrcA      = 1'b1;
        ALUOp        = 3'b001;
        BEQ          = w_is_beq;
        BNE          = w_is_bne;
        w_state_next = S_FETCH;
      end

      S_JUMP: begin
        w_pc_write   = 1'b1;
        PCSrc        = w_is_jr ? 2'b11 : 2'b10;
        w_reg_write  = w_is_jal;
        RetAdd       = w_is_jal;
        w_state_next = S_FETCH;
      end

      default: begin
        // TRAP: all outputs at their idle values, no way out except reset.
        w_state_next = S_TRAP;
      end
    endcase
  end

  assign PCWrite  = w_pc_write  & ~rst;
  assign IRWrite  = w_ir_write  & ~rst;
  assign MemRead  = w_mem_read  & ~rst;
  assign MemWrite = w_mem_write & ~rst;
  assign RegWrite = w_reg_write & ~rst;

  assign State   = r_state;
  assign Illegal = r_illegal;
  assign Timeout = r_timeout;

endmodule
